// File: rtl/req_ack_pkg.sv
// ============================================================================
// req_ack_pkg : shared state encoding and default sizing for req_ack_source
// Rev 1.0
// ============================================================================
`default_nettype none

package req_ack_pkg;

  localparam int DEF_WIDTH       = 4;
  localparam int DEF_ACK_TIMEOUT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/req_ack_source_en_counter.sv
// ============================================================================
// en_counter : enable-gated counter that wraps silently at 2^WIDTH
// Rev 1.0
// ============================================================================
`default_nettype none

module en_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] a
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] a_d;

  always_comb begin
    a_d = a_q;
    if (en) begin
      a_d = a_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
    end else begin
      a_q <= a_d;
    end
  end

  assign a = a_q;

endmodule

`default_nettype wire

// File: rtl/req_ack_source.sv
// ============================================================================
// req_ack_source : wrapping count stream plus four-phase publisher of a count
//                  snapshot taken on each rising edge of en. Rev 1.0
// ============================================================================
`default_nettype none

module req_ack_source
  import req_ack_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ack,
  output logic [WIDTH-1:0] a,
  output logic             req,
  output logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             timeout,
  output logic             overrun
);

  localparam int                TCNT_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(ACK_TIMEOUT - 1);

  logic [WIDTH-1:0]  a_cnt;
  logic              en_q;
  logic              capture;
  logic              tmo_hit;

  state_t            state_q,   state_d;
  logic [TCNT_W-1:0] tcnt_q,    tcnt_d;
  logic              req_q,     req_d;
  logic [WIDTH-1:0]  data_q,    data_d;
  logic              busy_q,    busy_d;
  logic              timeout_q, timeout_d;
  logic              overrun_q, overrun_d;

  en_counter #(
    .WIDTH (WIDTH)
  ) u_en_counter (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .a   (a_cnt)
  );

  assign capture = en && !en_q;
  assign tmo_hit = (tcnt_q == TCNT_MAX);

  // State register plus every registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      en_q      <= 1'b0;
      tcnt_q    <= '0;
      req_q     <= 1'b0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en;
      tcnt_q    <= tcnt_d;
      req_q     <= req_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  // ack wins over the timeout when both land in the same REQ cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack) begin
          state_d = DROP;
        end else if (tmo_hit) begin
          state_d = IDLE;
        end
      end
      DROP: begin
        if (!ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d     = req_q;
    data_d    = data_q;
    tcnt_d    = tcnt_q;
    timeout_d = 1'b0;
    overrun_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (capture) begin
          req_d  = 1'b1;
          data_d = a_cnt;
          tcnt_d = '0;
        end
      end
      REQ: begin
        overrun_d = capture;
        if (ack) begin
          req_d = 1'b0;
        end else if (tmo_hit) begin
          req_d     = 1'b0;
          timeout_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      DROP: begin
        overrun_d = capture;
      end
      default: begin
        req_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  assign a       = a_cnt;
  assign req     = req_q;
  assign data    = data_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;
  assign overrun = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_req_ack_source.sv
// ============================================================================
// tb_req_ack_source : directed and random stimulus against a transfer-level
//                     reference model of req_ack_source. Rev 1.0
// ============================================================================
`default_nettype none

module tb_req_ack_source;

  localparam int WIDTH       = 4;
  localparam int ACK_TIMEOUT = 8;
  localparam int MODN        = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b0;
  logic             ack = 1'b0;
  logic [WIDTH-1:0] a;
  logic             req;
  logic [WIDTH-1:0] data;
  logic             busy;
  logic             timeout;
  logic             overrun;

  int total = 0;
  int bad   = 0;

  // Reference model: one transfer at a time, described by how long req has
  // been high and whether we are waiting for ack to be released.
  int m_a        = 0;
  bit m_en_prev  = 0;
  bit m_in_xfer  = 0;
  bit m_req      = 0;
  int m_req_age  = 0;
  int m_data     = 0;
  bit m_timeout  = 0;
  bit m_overrun  = 0;

  int n_req_hi = 0;
  int n_to     = 0;
  int n_ov     = 0;

  req_ack_source #(
    .WIDTH       (WIDTH),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .ack     (ack),
    .a       (a),
    .req     (req),
    .data    (data),
    .busy    (busy),
    .timeout (timeout),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit e, input bit k, input bit r);
    bit ev;
    ev = e && !m_en_prev;
    m_timeout = 0;
    m_overrun = 0;
    if (r) begin
      m_a = 0; m_en_prev = 0; m_in_xfer = 0; m_req = 0;
      m_req_age = 0; m_data = 0;
      return;
    end
    if (!m_in_xfer) begin
      if (ev) begin
        m_data    = m_a;
        m_req     = 1;
        m_req_age = 1;
        m_in_xfer = 1;
      end
    end else begin
      m_overrun = ev;
      if (m_req) begin
        if (k) begin
          m_req = 0;
        end else if (m_req_age == ACK_TIMEOUT) begin
          m_req     = 0;
          m_in_xfer = 0;
          m_timeout = 1;
        end else begin
          m_req_age++;
        end
      end else if (!k) begin
        m_in_xfer = 0;
      end
    end
    if (e) m_a = (m_a + 1) % MODN;
    m_en_prev = e;
  endtask

  task automatic cycle(input bit e, input bit k, input bit r);
    en  = e;
    ack = k;
    rst = r;
    @(posedge clk);
    model_step(e, k, r);
    #1;
    chk("a",       32'(a),       32'(m_a));
    chk("req",     32'(req),     32'(m_req));
    chk("data",    32'(data),    32'(m_data));
    chk("busy",    32'(busy),    32'(m_in_xfer));
    chk("timeout", 32'(timeout), 32'(m_timeout));
    chk("overrun", 32'(overrun), 32'(m_overrun));
    if (req)     n_req_hi++;
    if (timeout) n_to++;
    if (overrun) n_ov++;
  endtask

  task automatic clr_counts();
    n_req_hi = 0;
    n_to     = 0;
    n_ov     = 0;
  endtask

  initial begin
    // Reset state
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    chk("rst_a",   32'(a),   32'd0);
    chk("rst_req", 32'(req), 32'd0);

    // Count and hold
    for (int i = 0; i < 6; i++) cycle(1, 0, 0);
    chk("count6", 32'(a), 32'd6);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0);
    chk("hold6", 32'(a), 32'd6);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0);

    // Wrap
    cycle(0, 0, 1);
    for (int i = 0; i < 20; i++) cycle(1, 0, 0);
    chk("wrap_end", 32'(a), 32'd4);

    // Handshake
    cycle(0, 0, 1);
    cycle(1, 0, 0);
    chk("hs_req_up",  32'(req),  32'd1);
    chk("hs_data",    32'(data), 32'd0);
    cycle(0, 0, 0);
    cycle(0, 1, 0);
    chk("hs_req_dn",  32'(req),  32'd0);
    chk("hs_busy",    32'(busy), 32'd1);
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    chk("hs_drop",    32'(busy), 32'd1);
    cycle(0, 0, 0);
    chk("hs_idle",    32'(busy), 32'd0);

    // Timeout
    cycle(0, 0, 1);
    clr_counts();
    cycle(1, 0, 0);
    for (int i = 0; i < 11; i++) cycle(0, 0, 0);
    chk("to_req_len", 32'(n_req_hi), 32'(ACK_TIMEOUT));
    chk("to_pulses",  32'(n_to),     32'd1);
    chk("to_busy",    32'(busy),     32'd0);

    // Overrun
    cycle(0, 0, 1);
    clr_counts();
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    chk("ov_pulses", 32'(n_ov), 32'd1);
    chk("ov_data",   32'(data), 32'd0);
    chk("ov_req",    32'(req),  32'd1);

    // Reset mid-transfer with en held high through release
    cycle(0, 0, 1);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    clr_counts();
    cycle(1, 0, 1);
    chk("mr_req", 32'(req),     32'd0);
    chk("mr_a",   32'(a),       32'd0);
    chk("mr_to",  32'(n_to),    32'd0);
    cycle(1, 0, 0);
    chk("mr_req_up", 32'(req),  32'd1);
    chk("mr_data",   32'(data), 32'd0);

    // Random traffic: a chatty downstream, then a sluggish one
    cycle(0, 0, 1);
    for (int i = 0; i < 400; i++) begin
      bit e, k, r;
      e = ($urandom_range(0, 2) != 0);
      if (i < 200) k = ($urandom_range(0, 2) == 0);
      else         k = ($urandom_range(0, 11) == 0);
      r = ($urandom_range(0, 59) == 0);
      cycle(e, k, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
